// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers, transform mode constants and FSM state encoding
// for the iterative MixColumns engine.
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; covers every MixColumns coefficient (01..0E).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// One-column MixColumns / InvMixColumns. Byte 0 of the column is col[31:24].
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        mode,
  output logic [31:0] mixed
);

  logic [7:0] a    [4];
  logic [7:0] b    [4];
  logic [3:0] coef [4];

  // Output byte j uses the base row rotated right by j: coefficient index (k - j) mod 4.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k] = col[31-8*k -: 8];
      b[k] = 8'h00;
    end
    if (mode == MODE_INV) begin
      coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        b[j] = b[j] ^ gmul(a[k], coef[2'(k - j)]);
      end
    end
    mixed = {b[0], b[1], b[2], b[3]};
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative, handshaked MixColumns / InvMixColumns engine.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for a state; in_ready=1
//   BUSY    | transforming COLS_PER_CYCLE columns per clock, in place
//   DONE    | result held on out with out_valid=1 until out_ready
//
// out is gated by out_valid so partially transformed columns never leak.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH   = 128,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in,
  input  logic                    mode,
  input  logic                    bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out
);

  if (BLOCK_LENGTH != 128) begin : g_bad_length
    $error("mix_columns_iter: BLOCK_LENGTH must be 128");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST  = 2'(STEPS - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [31:0] words_q [4];
  logic [31:0] words_d [4];

  logic        accept;
  logic [1:0]  col_sel [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);

  for (genvar c = 0; c < 4; c++) begin : g_out
    assign out[BLOCK_LENGTH-1-32*c -: 32] = out_valid ? words_q[c] : 32'h0;
  end

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
    assign col_sel[i] = 2'(int'(cnt_q) * COLS_PER_CYCLE + i);
    assign col_in[i]  = words_q[col_sel[i]];
    mix_column_word u_mix (
      .col   (col_in[i]),
      .mode  (mode_q),
      .mixed (col_out[i])
    );
  end

  // Next-state, counter and column demux; a new block may load straight out of DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          for (int c = 0; c < 4; c++) words_d[c] = in[BLOCK_LENGTH-1-32*c -: 32];
          mode_d  = mode;
          cnt_d   = 2'd0;
          state_d = bypass ? ST_DONE : ST_BUSY;
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) words_d[col_sel[i]] = col_out[i];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, mode and column registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      mode_q  <= MODE_FWD;
      for (int c = 0; c < 4; c++) words_q[c] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      words_q <= words_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench: three engines (1, 2 and 4 columns per clock) on shared data inputs,
// each with its own valid/ready handshake.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [127:0] in_data;
  logic         mode;
  logic         bypass;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] out_q [3];

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] RND1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] RND1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  always #5 clk = ~clk;

  mix_columns_iter #(.BLOCK_LENGTH(128), .COLS_PER_CYCLE(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(in_data),
    .mode(mode), .bypass(bypass), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out_q[0]));
  mix_columns_iter #(.BLOCK_LENGTH(128), .COLS_PER_CYCLE(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(in_data),
    .mode(mode), .bypass(bypass), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out_q[1]));
  mix_columns_iter #(.BLOCK_LENGTH(128), .COLS_PER_CYCLE(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in(in_data),
    .mode(mode), .bypass(bypass), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(out_q[2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count edges after accept until out_valid; the first edge is lat=1.
  task automatic wait_done(input int sel, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[sel] && lat < 20);
    check($sformatf("latency[%0d]", sel), 128'(lat), 128'(exp_lat));
  endtask

  // Accept one block, scramble the shared inputs afterwards, wait for the result.
  task automatic start_wait(input int sel, input logic [127:0] d, input logic m,
                            input logic b, input int exp_lat);
    @(negedge clk);
    in_data = d; mode = m; bypass = b; in_valid[sel] = 1'b1;
    #1 check($sformatf("in_ready_idle[%0d]", sel), 128'(in_ready[sel]), 128'd1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    in_data = ~d; mode = ~m; bypass = ~b;
    wait_done(sel, exp_lat);
  endtask

  task automatic release_out(input int sel);
    @(negedge clk) out_ready[sel] = 1'b1;
    @(posedge clk); #1 out_ready[sel] = 1'b0;
    check($sformatf("out_valid_drop[%0d]", sel), 128'(out_valid[sel]), 128'd0);
  endtask

  task automatic run_block(input int sel, input logic [127:0] d, input logic m, input logic b,
                           input int exp_lat, output logic [127:0] res);
    start_wait(sel, d, m, b, exp_lat);
    res = out_q[sel];
    release_out(sel);
  endtask

  initial begin
    logic [127:0] r1, r2, held, d;
    int lats [3];
    lats[0] = 4; lats[1] = 2; lats[2] = 1;
    rst_n = 1'b0; in_valid = '0; out_ready = '0; in_data = '0; mode = 1'b0; bypass = 1'b0;

    #12;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_in_ready[%0d]", s), 128'(in_ready[s]), 128'd1);
      check($sformatf("rst_out_valid[%0d]", s), 128'(out_valid[s]), 128'd0);
      check($sformatf("rst_out[%0d]", s), out_q[s], 128'h0);
    end
    @(negedge clk) rst_n = 1'b1;

    // FIPS-197 column example forward, then inverse back, on every width.
    for (int s = 0; s < 3; s++) begin
      run_block(s, FIPS_IN, 1'b0, 1'b0, lats[s], r1);
      check($sformatf("fips_fwd[%0d]", s), r1, FIPS_OUT);
      run_block(s, FIPS_OUT, 1'b1, 1'b0, lats[s], r2);
      check($sformatf("fips_inv[%0d]", s), r2, FIPS_IN);
    end

    // FIPS-197 Appendix B round 1 state.
    for (int s = 0; s < 3; s++) begin
      run_block(s, RND1_IN, 1'b0, 1'b0, lats[s], r1);
      check($sformatf("rnd1_fwd[%0d]", s), r1, RND1_OUT);
      run_block(s, RND1_OUT, 1'b1, 1'b0, lats[s], r2);
      check($sformatf("rnd1_inv[%0d]", s), r2, RND1_IN);
    end

    // Bypass for both modes: unchanged, one cycle.
    for (int s = 0; s < 3; s += 2) begin
      run_block(s, BYP_IN, 1'b0, 1'b1, 1, r1);
      check($sformatf("bypass_m0[%0d]", s), r1, BYP_IN);
      run_block(s, BYP_IN, 1'b1, 1'b1, 1, r1);
      check($sformatf("bypass_m1[%0d]", s), r1, BYP_IN);
    end

    // Backpressure: 10 stalled cycles, then back-to-back accept of the inverse.
    start_wait(0, FIPS_IN, 1'b0, 1'b0, 4);
    held = out_q[0];
    check("bp_first", held, FIPS_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_stable", out_q[0], FIPS_OUT);
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    @(negedge clk);
    in_data = FIPS_OUT; mode = 1'b1; bypass = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1 check("b2b_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b0; in_data = '0; mode = 1'b0;
    check("b2b_busy_no_valid", 128'(out_valid[0]), 128'd0);
    check("b2b_in_ready_busy", 128'(in_ready[0]), 128'd0);
    wait_done(0, 4);
    check("b2b_result", out_q[0], FIPS_IN);
    release_out(0);

    // Asynchronous reset: engine 1 held in DONE, engine 0 two cycles into BUSY.
    start_wait(1, RND1_IN, 1'b0, 1'b0, 2);
    check("pre_rst_done", out_q[1], RND1_OUT);
    @(negedge clk);
    in_data = FIPS_IN; mode = 1'b0; bypass = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_valid", 128'(out_valid[0]), 128'd0);
    check("rst_busy_out", out_q[0], 128'h0);
    check("rst_busy_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_done_valid", 128'(out_valid[1]), 128'd0);
    check("rst_done_out", out_q[1], 128'h0);
    @(negedge clk) rst_n = 1'b1;
    run_block(0, FIPS_IN, 1'b0, 1'b0, 4, r1);
    check("post_rst_fwd", r1, FIPS_OUT);

    // Random round trips: inverse of the forward result is the original state.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 6; k++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block(s, d, 1'b0, 1'b0, lats[s], r1);
        run_block(s, r1, 1'b1, 1'b0, lats[s], r2);
        check($sformatf("roundtrip[%0d]", s), r2, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
